instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: FIFO_DEPTH, 2, prefetch entries; only 2 is supported.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 memAddress  output  32  word-aligned fetch address.
REQ-006 memReadEnable  output  1  read request; held until accepted.
REQ-007 memDataIn  input  32  instruction word, valid when memReady=1.
REQ-008 memReady  input  1  completes the request on an edge where memReadEnable=1.
REQ-009 instrValid  output  1  FIFO head holds an instruction.
REQ-010 instrData  output  32  FIFO head instruction word.
REQ-011 instrPc  output  32  address that instrData was fetched from.
REQ-012 instrReady  input  1  downstream decoder consumes the head on an edge where instrValid=1.
REQ-013 redirectValid  input  1  one-cycle request to restart fetch at a new PC (branch/jump).
REQ-014 redirectPc  input  32  new fetch PC; bits [1:0] are forced to 0.

Function
REQ-015 The block SHALL keep at most one memory request outstanding.
- While memReadEnable=1 and memReady=0, memAddress SHALL hold stable.
REQ-016 Transfer: an edge with memReadEnable=1 and memReady=1 completes the request.
- The block SHALL push {memAddress, memDataIn} into the FIFO at that edge unless the response is marked discard.
REQ-017 The FSM SHALL have exactly three states:
- FETCH: request active.
- STALL: no request; FIFO has no free slot.
- DRAIN: request active; response marked discard.
REQ-018 At a completing edge in FETCH, the block SHALL set memAddress <= memAddress+4 and keep memReadEnable=1 if the post-edge FIFO count is at most 1; otherwise it SHALL enter STALL with memReadEnable=0.
REQ-019 In STALL, the block SHALL enter FETCH at the first edge where the post-edge FIFO count is at most 1, asserting memReadEnable=1 at the next sequential address.
REQ-020 Zero-wait memory (memReady tied high) with instrReady high SHALL sustain one instruction per cycle.
REQ-021 Minimum latency: memReadEnable rises at edge N; with memReady=1, instrValid SHALL be high after edge N+1.
REQ-022 Pop: an edge with instrValid=1 and instrReady=1 SHALL remove the head entry.
- Push and pop at the same edge SHALL leave the count unchanged.
REQ-023 Address arithmetic SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-024 Redirect: an edge with redirectValid=1 SHALL flush the FIFO, so instrValid=0 after that edge. Redirect overrides any push or pop at the same edge.
REQ-025 Redirect with no request pending, or coinciding with a completing edge: at that edge the block SHALL set memAddress <= {redirectPc[31:2],2'b00}, memReadEnable=1, and state FETCH; the coinciding response SHALL be discarded.
REQ-026 Redirect while a request is pending without memReady: the block SHALL enter DRAIN, keep address and request stable, and store the redirect PC.
- On the completing edge in DRAIN, the data SHALL be discarded and fetch SHALL proceed from the stored PC in FETCH.
REQ-027 A second redirect during DRAIN SHALL overwrite the stored PC; the last redirect wins.
REQ-028 A full FIFO SHALL never be pushed; the capacity rule in REQ-018 guarantees this, and an assertion SHALL check it.

Reset
REQ-029 Reset asserted (reset=0) SHALL immediately force:
- memReadEnable=0, memAddress=RESET_PC
- FIFO empty, so instrValid=0
- instrData=0, instrPc=0
- stored redirect PC=0, state FETCH
REQ-030 At the first edge after reset deasserts, memReadEnable SHALL rise with memAddress=RESET_PC.
REQ-031 Reset asserted mid-transfer SHALL abandon the request; no response arriving before or during reset SHALL be pushed.

Structure
REQ-032 The shared CPU package SHALL hold the FSM state encoding, RESET_PC default, and FETCH_FIFO_DEPTH.
REQ-033 The 2-entry FIFO SHALL be a sub-module named fetch_fifo with push, pop, flush, count, and a 64-bit {pc, instr} payload.

Verification
REQ-034 Reset release, memReady=1, instrReady=1: memAddress steps 0,4,8,C on consecutive cycles; instrPc follows one cycle later; instrValid stays continuously high.
REQ-035 instrReady=0 from reset: exactly two pushes (PC 0,4); then memReadEnable=0 (STALL). One pop fetches 8 and no further address.
REQ-036 memReady delayed 3 cycles on address 4: memAddress holds 4 for all three cycles; instrValid gaps without duplicate or lost PCs.
REQ-037 redirectValid=1, redirectPc=32'h100 while address 8 is waiting: FIFO empties at once; the response for 8 is dropped; next request is 0x100; first instrPc is 0x100.
REQ-038 redirectPc=32'h203 coinciding with memReady: response discarded; next memAddress=0x200.
REQ-039 reset driven low during a pending request, then released: outputs hold reset values while low; first request after release is RESET_PC; no stale instruction appears.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions for the fetch stage: FSM encoding, reset PC default,
// prefetch depth and a word-alignment helper.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_STALL = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          FETCH_FIFO_DEPTH = 2;

    function automatic logic [31:0] align_word(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry prefetch FIFO holding {pc, instr}; entry0 is always the head, so
// the head outputs come straight from a register.
module fetch_fifo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [63:0] push_data,
    output logic [63:0] head_data,
    output logic        head_valid,
    output logic [1:0]  count
);

    logic [63:0] entry0_q, entry0_d;
    logic [63:0] entry1_q, entry1_d;
    logic [1:0]  count_q, count_d;

    // Next-state for storage and occupancy; flush wins over push and pop.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        entry0_d = push_data;
                    end else begin
                        entry1_d = push_data;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    entry0_d = entry1_q;
                    count_d  = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        entry0_d = push_data;
                    end else begin
                        entry0_d = entry1_q;
                        entry1_d = push_data;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // Storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_q <= 64'd0;
            entry1_q <= 64'd0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign head_data  = entry0_q;
    assign head_valid = (count_q != 2'd0);
    assign count      = count_q;

    fetch_fifo_checker u_checker (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .flush (flush),
        .count (count_q)
    );

endmodule

// File: rtl/fetch_fifo_checker.sv
// Property checks for the prefetch FIFO; a full FIFO must never see a push.
module fetch_fifo_checker (
    input logic       clk,
    input logic       rst_n,
    input logic       push,
    input logic       flush,
    input logic [1:0] count
);

    no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && !flush && (count == 2'd2))
    );

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding memory requester feeding a 2-entry
// prefetch FIFO, with branch redirect and in-flight response discard.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] memAddress,
    output logic        memReadEnable,
    input  logic [31:0] memDataIn,
    input  logic        memReady,
    output logic        instrValid,
    output logic [31:0] instrData,
    output logic [31:0] instrPc,
    input  logic        instrReady,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc
);

    localparam logic [2:0] SPACE_LIMIT = 3'(FIFO_DEPTH - 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic         re_q, re_d;
    logic [31:0]  redir_q, redir_d;

    logic         push_s, flush_s, pop_s;
    logic [1:0]   count_s;
    logic         fifo_valid_s;
    logic [63:0]  head_s;
    logic [2:0]   post_fetch_s;
    logic [2:0]   post_stall_s;

    assign pop_s        = fifo_valid_s && instrReady && !redirectValid;
    // Occupancy after this edge if a response lands (FETCH) or not (STALL).
    assign post_fetch_s = {1'b0, count_s} + 3'd1 - {2'b00, pop_s};
    assign post_stall_s = {1'b0, count_s} - {2'b00, pop_s};

    // Fetch sequencing: redirect first, then per-state request handling.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        re_d    = re_q;
        redir_d = redir_q;
        push_s  = 1'b0;
        flush_s = 1'b0;
        if (redirectValid) begin
            flush_s = 1'b1;
            if (re_q && !memReady) begin
                state_d = ST_DRAIN;
                redir_d = align_word(redirectPc);
            end else begin
                state_d = ST_FETCH;
                addr_d  = align_word(redirectPc);
                re_d    = 1'b1;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!re_q) begin
                        re_d = 1'b1;
                    end else if (memReady) begin
                        push_s = 1'b1;
                        addr_d = addr_q + 32'd4;
                        if (post_fetch_s <= SPACE_LIMIT) begin
                            re_d = 1'b1;
                        end else begin
                            re_d    = 1'b0;
                            state_d = ST_STALL;
                        end
                    end else begin
                        re_d = re_q;
                    end
                end
                ST_STALL: begin
                    if (post_stall_s <= SPACE_LIMIT) begin
                        re_d    = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        re_d = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (memReady) begin
                        addr_d  = redir_q;
                        re_d    = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        re_d = re_q;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                    re_d    = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and registered memory-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            addr_q  <= RESET_PC;
            re_q    <= 1'b0;
            redir_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            re_q    <= re_d;
            redir_q <= redir_d;
        end
    end

    fetch_fifo u_fetch_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (flush_s),
        .push_data  ({addr_q, memDataIn}),
        .head_data  (head_s),
        .head_valid (fifo_valid_s),
        .count      (count_s)
    );

    assign memAddress    = addr_q;
    assign memReadEnable = re_q;
    assign instrValid    = fifo_valid_s;
    assign instrPc       = head_s[63:32];
    assign instrData     = head_s[31:0];

endmodule
